alu_seq_muldiv: RTL
===================

// Module: alu_seq_muldiv
// PURPOSE
//  Parametrised, handshaked successor of the pipeline CPU's single-cycle ALU.
//  Adds registered results, signed/unsigned high-word multiply, and optional divide/remainder.
//  Single-cycle ops take 1 cycle; iterative multiply/divide takes WIDTH cycles.
//  Sits in EX; the hazard unit stalls the pipeline while in_ready or out_valid is low.
// PARAMETERS
//  WIDTH     32  operand/result width; even, >=8
//  SHAMT_W   5   shift-amount bits = $clog2(WIDTH); derived, do not override
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation request
//  in_ready   out  1      block can accept a request
//  alu_ctl    in   4      opcode, encoding below
//  sign       in   1      1 = signed compare/mulh/div
//  in1        in   WIDTH  operand A; also the shift amount
//  in2        in   WIDTH  operand B; also the value shifted
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      consumer accepts result
//  out        out  WIDTH  registered result
//  busy       out  1      iterative op in progress (MUL/DIV state)
// BEHAVIOUR
//  Opcodes: 0 add, 1 sub, 2 mul(lo), 3 mulh(hi; signedness per sign), 4 and, 5 or, 6 xor, 7 nor,
//   8 sll in2<<in1[SHAMT_W-1:0], 9 srl, 10 sra, 11 slt (signed per sign, zero-extended),
//   12 div, 13 rem, 14/15 -> result 0.
//  Request is accepted when in_valid && in_ready; operands and opcode are captured in that cycle.
//  FSM: IDLE -> (simple op) DONE; IDLE -> MUL | DIV -> DONE; DONE -> IDLE on out_ready.
//   DONE -> next op directly if out_ready && in_valid (back-to-back).
//  in_ready = (state==IDLE) || (state==DONE && out_ready).
//  out_valid = (state==DONE). out and out_valid stay stable while out_ready is low.
//  Latency, accept at cycle T: simple op out_valid at T+1; mul/mulh/div/rem at T+WIDTH+1.
//  MUL: radix-2 shift-add on magnitudes with a 2*WIDTH accumulator; negate the final product when
//   sign && (in1[W-1]^in2[W-1]).
//  DIV: restoring, one quotient bit per cycle on magnitudes.
//   Quotient sign = XOR of operand signs; remainder sign = dividend sign.
//  Divide by zero: quotient all-ones, remainder = in1. Signed MIN/-1: quotient MIN, remainder 0.
//  add/sub/mul wrap modulo 2^WIDTH; no flags.
//  Request while busy: in_ready is low, so the request is ignored (no capture).
//  Reset asserted at any time, including mid-iteration: state IDLE, out=0, out_valid=0, busy=0,
//   internal registers cleared. After reset release in_ready=1.
// CONFIGURATION
//  ALU_DIV_EN defined: opcodes 12/13 iterate in DIV as above.
//  ALU_DIV_EN undefined: no divider hardware; 12/13 behave as simple ops with result 0,
//   out_valid at T+1.
// STRUCTURE
//  Package alu_pkg: ALU_ADD..ALU_REM opcode localparams, state typedef {IDLE,MUL,DIV,DONE},
//   is_iterative() helper.
//  Sub-module alu_iter_muldiv: iteration counter, accumulator/remainder datapath, start/done pulses.
//   Top owns the FSM, the simple-op datapath, and the output register.
// TESTING
//  1 add 32'h7FFFFFFF + 1, accept T -> out 32'h80000000, out_valid at T+1, busy never high
//  2 sra: in1=4, in2=32'hF0000000 -> 32'hFF000000; slt sign=1 with -1 vs 1 -> 1; sign=0 -> 0
//  3 mulh sign=1: -2 * 3 -> 32'hFFFFFFFF; mul -> 32'hFFFFFFFA; out_valid exactly at T+33
//  4 ALU_DIV_EN: div -7/2 sign=1 -> 32'hFFFFFFFD, rem -> 32'hFFFFFFFF; div 5/0 -> 32'hFFFFFFFF;
//    rem 5/0 -> 5; div 32'h80000000/-1 -> 32'h80000000
//  5 out_ready low 3 cycles after a result -> out stable, in_ready 0; then out_ready with in_valid
//    -> next op accepted same cycle
//  6 rst_n pulsed at iteration 10 of a mul -> out_valid 0 immediately; next add completes normally

Source files
------------

// File: rtl/alu_seq_muldiv_pkg.sv
// Shared opcode encoding, FSM state type and the iterative-op classifier
// for alu_seq_muldiv. Optional divider: define ALU_DIV_EN.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_MUL  = 4'd2;
   localparam logic [3:0] ALU_MULH = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_OR   = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_NOR  = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_SLT  = 4'd11;
   localparam logic [3:0] ALU_DIV  = 4'd12;
   localparam logic [3:0] ALU_REM  = 4'd13;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

   // Opcodes that go through the WIDTH-cycle iterative unit
   function automatic logic is_iterative(input logic [3:0] op);
`ifdef ALU_DIV_EN
      return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
`else
      return (op == ALU_MUL) || (op == ALU_MULH);
`endif
   endfunction

endpackage

// File: rtl/alu_seq_muldiv_if.sv
// Request/response handshake bundle between the EX stage and alu_seq_muldiv.
interface alu_seq_muldiv_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_ctl;
   logic             sign;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             busy;

   modport master (
      output in_valid, alu_ctl, sign, in1, in2, out_ready,
      input  in_ready, out_valid, out, busy
   );

   modport slave (
      input  in_valid, alu_ctl, sign, in1, in2, out_ready,
      output in_ready, out_valid, out, busy
   );
endinterface

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative multiply (radix-2 shift-add) and, with ALU_DIV_EN, restoring
// divide. Works on magnitudes; sign is fixed up on the last step.
// sel_i[1]: divide, sel_i[0]: high word (mul) / remainder (div).
module alu_iter_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [1:0]       sel_i,
   input  logic             sign_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);
   localparam int               CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   // acc holds {hi, lo}: mul = {partial sum, multiplier}, div = {remainder, quotient}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         sel_q, sel_d;
   logic               run_q, run_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] step, prod;
`ifdef ALU_DIV_EN
   logic               rneg_q, rneg_d;
   logic               div0_q, div0_d;
   logic [WIDTH:0]     div_shift, div_diff;
   logic [WIDTH-1:0]   quo, rem;
`else
   logic               unused_div;
   assign unused_div = sel_q[1];
`endif

   assign a_mag  = (sign_i && a_i[WIDTH-1]) ? -a_i : a_i;
   assign b_mag  = (sign_i && b_i[WIDTH-1]) ? -b_i : b_i;
   assign done_o = run_q && (cnt_q == LAST);

   // One iteration step of the selected algorithm
   always_comb begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      step    = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd_q};
      if (sel_q[1])
         step = {div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0],
                 acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
`endif
   end

   // Final result from the last step, with sign and divide-by-zero fixups
   always_comb begin
      prod     = neg_q ? -step : step;
      result_o = sel_q[0] ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
      quo = div0_q ? '1 : (neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]);
      rem = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
      if (sel_q[1]) result_o = sel_q[0] ? rem : quo;
`endif
   end

   // Load operands on start, then step once per cycle for WIDTH cycles
   always_comb begin
      acc_d  = acc_q;
      opnd_d = opnd_q;
      cnt_d  = cnt_q;
      sel_d  = sel_q;
      run_d  = run_q;
      neg_d  = neg_q;
`ifdef ALU_DIV_EN
      rneg_d = rneg_q;
      div0_d = div0_q;
`endif
      if (start_i) begin
         run_d  = 1'b1;
         cnt_d  = '0;
         sel_d  = sel_i;
         neg_d  = sign_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
         acc_d  = {{WIDTH{1'b0}}, b_mag};
         opnd_d = a_mag;
`ifdef ALU_DIV_EN
         rneg_d = sign_i && a_i[WIDTH-1];
         div0_d = (b_i == '0);
         if (sel_i[1]) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
         end
`endif
      end else if (run_q) begin
         acc_d = step;
         cnt_d = cnt_q + 1'b1;
         if (done_o) run_d = 1'b0;
      end
   end

   // Iteration state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
         sel_q  <= '0;
         run_q  <= 1'b0;
         neg_q  <= 1'b0;
`ifdef ALU_DIV_EN
         rneg_q <= 1'b0;
         div0_q <= 1'b0;
`endif
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         cnt_q  <= cnt_d;
         sel_q  <= sel_d;
         run_q  <= run_d;
         neg_q  <= neg_d;
`ifdef ALU_DIV_EN
         rneg_q <= rneg_d;
         div0_q <= div0_d;
`endif
      end
   end
endmodule

// File: rtl/alu_seq_muldiv.sv
// Handshaked EX-stage ALU with registered result. Simple ops finish in one
// cycle; mul/mulh (and div/rem when ALU_DIV_EN is defined) take WIDTH cycles.
module alu_seq_muldiv import alu_pkg::*; #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input logic             clk,
   input logic             rst_n,
   alu_seq_muldiv_if.slave bus
);
   state_e             state_q, state_d, launch;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [WIDTH-1:0]   simple_res, iter_res;
   logic               accept, is_iter, start, iter_done, lt;
   logic [1:0]         sel;
   logic [SHAMT_W-1:0] sh;

   assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q == MUL) || (state_q == DIV);
   assign bus.out       = out_q;

   assign accept  = bus.in_valid && bus.in_ready;
   assign is_iter = is_iterative(bus.alu_ctl);
   assign start   = accept && is_iter;
   assign sel     = {(bus.alu_ctl == ALU_DIV)  || (bus.alu_ctl == ALU_REM),
                     (bus.alu_ctl == ALU_MULH) || (bus.alu_ctl == ALU_REM)};
   assign sh      = bus.in1[SHAMT_W-1:0];
   assign lt      = bus.sign ? ($signed(bus.in1) < $signed(bus.in2)) : (bus.in1 < bus.in2);

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start),
      .sel_i    (sel),
      .sign_i   (bus.sign),
      .a_i      (bus.in1),
      .b_i      (bus.in2),
      .done_o   (iter_done),
      .result_o (iter_res)
   );

   // Single-cycle datapath; iterative and unused opcodes yield 0 here
   always_comb begin
      simple_res = '0;
      case (bus.alu_ctl)
         ALU_ADD: simple_res = bus.in1 + bus.in2;
         ALU_SUB: simple_res = bus.in1 - bus.in2;
         ALU_AND: simple_res = bus.in1 & bus.in2;
         ALU_OR:  simple_res = bus.in1 | bus.in2;
         ALU_XOR: simple_res = bus.in1 ^ bus.in2;
         ALU_NOR: simple_res = ~(bus.in1 | bus.in2);
         ALU_SLL: simple_res = bus.in2 << sh;
         ALU_SRL: simple_res = bus.in2 >> sh;
         ALU_SRA: simple_res = $unsigned($signed(bus.in2) >>> sh);
         ALU_SLT: simple_res = {{(WIDTH-1){1'b0}}, lt};
         default: simple_res = '0;
      endcase
   end

   // Next state and output-register update
   always_comb begin
      launch  = is_iter ? (sel[1] ? DIV : MUL) : DONE;
      state_d = state_q;
      out_d   = out_q;
      case (state_q)
         IDLE:     if (accept) state_d = launch;
         MUL, DIV: if (iter_done) state_d = DONE;
         DONE:     if (bus.out_ready) state_d = accept ? launch : IDLE;
         default:  state_d = IDLE;
      endcase
      if (accept && !is_iter) out_d = simple_res;
      else if (iter_done)     out_d = iter_res;
   end

   // State and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end
endmodule
